// File: rtl/cov_fsm.sv
// cov_fsm: run sequencer for the compare/exchange/remainder datapath.
// Walks the INIT, CHECK, EXCHANGE, PRELOOP and LOOP phases and steers them
// with registered sign and zero flags from the datapath. The state code is
// registered and feeds the control-signal decoder directly.
// Optional feature: define COV_FSM_WATCHDOG_EN to build a LOOP1-entry
// watchdog that ends a run through END2 and raises a sticky timeout.
module cov_fsm #(
  parameter logic [15:0] WD_LIMIT = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       flag_s1,
  input  logic       flag_z1,
  output logic [4:0] state,
  output logic       timeout
);

  // state      | meaning
  // IDLE       | waiting for start
  // INIT1..4   | load operands; INIT4 rejects m<0
  // CHECK1..8  | argument checks (n<0, n==0, m==0) and m<n compare
  // EXCHANGE1-3| swap m and n
  // PRELOOP1-2 | set up trial divisor
  // LOOP1..6   | divide m by i (LOOP2..4 divider window); LOOP6 tests m mod i
  // LOOP7..11  | divide n by i; LOOP11 tests n mod i
  // END1       | write result
  // END2       | write error / timeout result
  // code 31    | unused, recovers to IDLE
  typedef enum logic [4:0] {
    IDLE      = 5'd0,
    INIT1     = 5'd1,  INIT2     = 5'd2,  INIT3     = 5'd3,  INIT4  = 5'd4,
    CHECK1    = 5'd5,  CHECK2    = 5'd6,  CHECK3    = 5'd7,  CHECK4 = 5'd8,
    CHECK5    = 5'd9,  CHECK6    = 5'd10, CHECK7    = 5'd11, CHECK8 = 5'd12,
    EXCHANGE1 = 5'd13, EXCHANGE2 = 5'd14, EXCHANGE3 = 5'd15,
    PRELOOP1  = 5'd16, PRELOOP2  = 5'd17,
    LOOP1     = 5'd18, LOOP2     = 5'd19, LOOP3     = 5'd20, LOOP4  = 5'd21,
    LOOP5     = 5'd22, LOOP6     = 5'd23, LOOP7     = 5'd24, LOOP8  = 5'd25,
    LOOP9     = 5'd26, LOOP10    = 5'd27, LOOP11    = 5'd28,
    END1      = 5'd29, END2      = 5'd30
  } state_t;

  state_t state_q;
  state_t state_d;

`ifdef COV_FSM_WATCHDOG_EN
  logic [15:0] wd_cnt_q;
  logic        timeout_q;
  logic        launch;
  logic        loop_entry;
  logic        wd_trip;

  assign launch = (state_q == IDLE) && start;
`endif

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; flags are only looked at in the decision states.
  always_comb begin
    state_d = state_q;
`ifdef COV_FSM_WATCHDOG_EN
    loop_entry = 1'b0;
    wd_trip    = 1'b0;
`endif
    case (state_q)
      IDLE:      if (start) state_d = INIT1;
      INIT1:     state_d = INIT2;
      INIT2:     state_d = INIT3;
      INIT3:     state_d = INIT4;
      INIT4:     state_d = flag_s1 ? END2 : CHECK1;
      CHECK1:    state_d = CHECK2;
      CHECK2:    state_d = flag_s1 ? END2 : CHECK3;
      CHECK3:    state_d = CHECK4;
      CHECK4:    state_d = flag_z1 ? END2 : CHECK5;
      CHECK5:    state_d = CHECK6;
      CHECK6:    state_d = flag_z1 ? END2 : CHECK7;
      CHECK7:    state_d = CHECK8;
      CHECK8:    state_d = flag_s1 ? EXCHANGE1 : PRELOOP1;
      EXCHANGE1: state_d = EXCHANGE2;
      EXCHANGE2: state_d = EXCHANGE3;
      EXCHANGE3: state_d = PRELOOP1;
      PRELOOP1:  state_d = PRELOOP2;
      PRELOOP2:  state_d = LOOP1;
      LOOP1:     state_d = LOOP2;
      LOOP2:     state_d = LOOP3;
      LOOP3:     state_d = LOOP4;
      LOOP4:     state_d = LOOP5;
      LOOP5:     state_d = LOOP6;
      LOOP6:     state_d = flag_z1 ? LOOP7 : LOOP1;
      LOOP7:     state_d = LOOP8;
      LOOP8:     state_d = LOOP9;
      LOOP9:     state_d = LOOP10;
      LOOP10:    state_d = LOOP11;
      LOOP11:    state_d = flag_z1 ? END1 : LOOP1;
      END1:      state_d = IDLE;
      END2:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
`ifdef COV_FSM_WATCHDOG_EN
    // LOOP1 is never followed by itself, so any move into it is an entry.
    loop_entry = (state_d == LOOP1);
    if (loop_entry && ((wd_cnt_q + 16'd1) == WD_LIMIT)) begin
      state_d = END2;
      wd_trip = 1'b1;
    end
`endif
    // Abort wins over everything, including the watchdog trip.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
`ifdef COV_FSM_WATCHDOG_EN
      loop_entry = 1'b0;
      wd_trip    = 1'b0;
`endif
    end
  end

`ifdef COV_FSM_WATCHDOG_EN
  // LOOP1-entry counter, restarted with each new run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           wd_cnt_q <= '0;
    else if (launch)     wd_cnt_q <= '0;
    else if (loop_entry) wd_cnt_q <= wd_cnt_q + 16'd1;
  end

  // Sticky trip flag, held until the next run starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        timeout_q <= 1'b0;
    else if (launch)  timeout_q <= 1'b0;
    else if (wd_trip) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  // Without the watchdog the loop is unbounded and WD_LIMIT has no effect.
  logic unused_wd_limit;
  assign unused_wd_limit = ^WD_LIMIT;
  assign timeout = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_cov_fsm.sv
// Directed bench for cov_fsm. Inputs change 1 ns after each rising edge;
// outputs are checked at that point too, against hand-derived state codes.
module tb_cov_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       flag_s1 = 1'b0;
  logic       flag_z1 = 1'b0;
  logic [4:0] state;
  logic       timeout;

  int n_chk = 0;
  int n_bad = 0;

`ifdef COV_FSM_WATCHDOG_EN
  localparam int NRET = 1;
`else
  localparam int NRET = 2;
`endif

  cov_fsm #(.WD_LIMIT(16'd3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .flag_s1 (flag_s1),
    .flag_z1 (flag_z1),
    .state   (state),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive inputs for the current state, take one edge, check the new state.
  task automatic go(input logic s1, input logic z1, input logic st, input logic ab,
                    input logic [4:0] exp, input string tag);
    flag_s1 = s1;
    flag_z1 = z1;
    start   = st;
    abort   = ab;
    @(posedge clk);
    #1;
    chk_val(tag, {11'd0, state}, {11'd0, exp});
  endtask

  // From IDLE, a clean run up to the first LOOP1 (optionally via EXCHANGE).
  task automatic run_to_loop1(input logic xchg);
    go(0, 0, 1, 0, 5'd1, "launch");
    for (int k = 2; k <= 12; k++) go(0, 0, 0, 0, 5'(k), "checks");
    if (xchg) begin
      go(1, 0, 0, 0, 5'd13, "xchg1");
      go(0, 0, 0, 0, 5'd14, "xchg2");
      go(0, 0, 0, 0, 5'd15, "xchg3");
      go(0, 0, 0, 0, 5'd16, "pre1");
    end else begin
      go(0, 0, 0, 0, 5'd16, "pre1_direct");
    end
    go(0, 0, 0, 0, 5'd17, "pre2");
    go(0, 0, 0, 0, 5'd18, "loop1");
  endtask

  // From LOOP1 through LOOP6, with flag_z1=z at LOOP6.
  task automatic loop_pass(input logic z, input logic [4:0] exp);
    for (int k = 19; k <= 23; k++) go(0, 0, 0, 0, 5'(k), "loop_body");
    go(0, z, 0, 0, exp, "loop6_exit");
  endtask

  initial begin
    #2;
    chk_val("reset_state", {11'd0, state}, 16'd0);
    chk_val("reset_timeout", {15'd0, timeout}, 16'd0);
    #20;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Idle holds without start, and ignores flags.
    go(0, 0, 0, 0, 5'd0, "idle_hold");
    go(1, 1, 0, 0, 5'd0, "idle_flags");

    // m<0 rejected at INIT4.
    go(0, 0, 1, 0, 5'd1, "a_init1");
    go(0, 0, 0, 0, 5'd2, "a_init2");
    go(0, 0, 0, 0, 5'd3, "a_init3");
    go(0, 0, 0, 0, 5'd4, "a_init4");
    go(1, 0, 0, 0, 5'd30, "a_end2");
    go(0, 0, 0, 0, 5'd0, "a_idle");

    // n<0 at CHECK2; zero flag at INIT4 and sign at CHECK1 are ignored.
    go(0, 0, 1, 0, 5'd1, "b_init1");
    go(0, 0, 0, 0, 5'd2, "b_init2");
    go(0, 0, 0, 0, 5'd3, "b_init3");
    go(0, 0, 0, 0, 5'd4, "b_init4");
    go(0, 1, 0, 0, 5'd5, "b_check1");
    go(1, 0, 0, 0, 5'd6, "b_check2");
    go(1, 0, 0, 0, 5'd30, "b_end2");
    go(0, 0, 0, 0, 5'd0, "b_idle");

    // n==0 at CHECK4.
    go(0, 0, 1, 0, 5'd1, "c_init1");
    for (int k = 2; k <= 8; k++) go(0, 0, 0, 0, 5'(k), "c_walk");
    go(0, 1, 0, 0, 5'd30, "c_end2");
    go(0, 0, 0, 0, 5'd0, "c_idle");

    // Full run with exchange, loop returns, start held high late in the run.
    run_to_loop1(1'b1);
    for (int r = 0; r < NRET; r++) loop_pass(1'b0, 5'd18);
    loop_pass(1'b1, 5'd24);
    for (int k = 25; k <= 28; k++) go(0, 0, 1, 0, 5'(k), "d_start_ignored");
    go(0, 1, 1, 0, 5'd29, "d_end1");
    go(0, 0, 1, 0, 5'd0, "d_end1_idle");
    go(0, 0, 1, 0, 5'd1, "d_relaunch");
    go(0, 0, 0, 1, 5'd0, "d_abort_init1");

    // LOOP11 without zero returns to LOOP1, then abort in LOOP3.
    run_to_loop1(1'b0);
    loop_pass(1'b1, 5'd24);
    for (int k = 25; k <= 28; k++) go(0, 0, 0, 0, 5'(k), "e_walk");
    go(0, 0, 0, 0, 5'd18, "e_loop11_back");
    go(0, 0, 0, 0, 5'd19, "e_loop2");
    go(0, 0, 0, 0, 5'd20, "e_loop3");
    go(0, 0, 0, 1, 5'd0, "e_abort_loop3");
    go(0, 0, 0, 0, 5'd0, "e_idle");

    // Abort during END1 goes straight to IDLE without END2.
    run_to_loop1(1'b0);
    loop_pass(1'b1, 5'd24);
    for (int k = 25; k <= 28; k++) go(0, 0, 0, 0, 5'(k), "f_walk");
    go(0, 1, 0, 0, 5'd29, "f_end1");
    go(0, 0, 0, 1, 5'd0, "f_abort_end1");
    go(0, 0, 0, 0, 5'd0, "f_no_end2");

`ifdef COV_FSM_WATCHDOG_EN
    // Third LOOP1 entry becomes END2 and timeout sticks until next start.
    run_to_loop1(1'b0);
    loop_pass(1'b0, 5'd18);
    loop_pass(1'b0, 5'd30);
    chk_val("wd_timeout_set", {15'd0, timeout}, 16'd1);
    go(0, 0, 0, 0, 5'd0, "wd_idle");
    chk_val("wd_timeout_hold", {15'd0, timeout}, 16'd1);
    go(0, 0, 1, 0, 5'd1, "wd_restart");
    chk_val("wd_timeout_clear", {15'd0, timeout}, 16'd0);
    go(0, 0, 0, 1, 5'd0, "wd_abort");
`else
    // No watchdog: the loop keeps going past three entries.
    run_to_loop1(1'b0);
    for (int r = 0; r < 3; r++) loop_pass(1'b0, 5'd18);
    chk_val("nowd_timeout", {15'd0, timeout}, 16'd0);
    go(0, 0, 0, 1, 5'd0, "nowd_abort");
`endif

    // Reset between edges in LOOP9 returns to IDLE at once.
    run_to_loop1(1'b0);
    loop_pass(1'b1, 5'd24);
    go(0, 0, 0, 0, 5'd25, "g_loop8");
    go(0, 0, 0, 0, 5'd26, "g_loop9");
    #2;
    reset = 1'b1;
    #1;
    chk_val("g_async_state", {11'd0, state}, 16'd0);
    chk_val("g_async_timeout", {15'd0, timeout}, 16'd0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_val("g_after_release", {11'd0, state}, 16'd0);
    go(0, 0, 0, 0, 5'd0, "g_stay_idle");
    go(0, 0, 1, 0, 5'd1, "g_first_start");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cov_fsm.md
COV_FSM -- requirements
Module: cov_fsm

Interface
REQ-001 Parameter WD_LIMIT, default 16'd1000, maximum LOOP1 entries per run before watchdog trip (used only with COV_FSM_WATCHDOG_EN).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous abort request; effective in any non-IDLE state.
REQ-006 flag_s1  input  1  registered datapath sign flag, valid in the cycle after a SET_S1 state.
REQ-007 flag_z1  input  1  registered datapath zero flag, valid in the cycle after a SET_Z1 state.
REQ-008 state  output  5  current state code, registered, drives the control-signal decoder.
REQ-009 timeout  output  1  sticky watchdog-trip indication for the current/last run.

Function
REQ-010 Encoding SHALL be: IDLE 0, INIT1..INIT4 1..4, CHECK1..CHECK8 5..12, EXCHANGE1..3 13..15, PRELOOP1..2 16..17, LOOP1..LOOP11 18..28, END1 29, END2 30.
REQ-011 state SHALL be the state register output directly (no combinational path from inputs to state).
REQ-012 IDLE: start=1 -> INIT1; else remain IDLE.
REQ-013 INIT1->INIT2->INIT3->INIT4 unconditionally, one cycle each.
REQ-014 INIT4: flag_s1=1 (m<0) -> END2; else -> CHECK1.
REQ-015 CHECK1->CHECK2; CHECK2: flag_s1=1 (n<0) -> END2, else -> CHECK3.
REQ-016 CHECK3->CHECK4; CHECK4: flag_z1=1 (n==0) -> END2, else -> CHECK5.
REQ-017 CHECK5->CHECK6; CHECK6: flag_z1=1 (m==0) -> END2, else -> CHECK7.
REQ-018 CHECK7->CHECK8; CHECK8: flag_s1=1 (m<n) -> EXCHANGE1, else -> PRELOOP1.
REQ-019 EXCHANGE1->EXCHANGE2->EXCHANGE3->PRELOOP1->PRELOOP2->LOOP1 unconditionally.
REQ-020 LOOP1->LOOP2->LOOP3->LOOP4->LOOP5->LOOP6 unconditionally (3-cycle divider window LOOP2..LOOP4).
REQ-021 LOOP6: flag_z1=1 (m mod i == 0) -> LOOP7; else -> LOOP1.
REQ-022 LOOP7->LOOP8->LOOP9->LOOP10->LOOP11 unconditionally.
REQ-023 LOOP11: flag_z1=1 (n mod i == 0) -> END1; else -> LOOP1.
REQ-024 END1 -> IDLE and END2 -> IDLE unconditionally (single write cycle each).
REQ-025 Flags SHALL be examined only in INIT4, CHECK2/4/6/8, LOOP6, LOOP11; ignored elsewhere.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE next cycle, overriding all other transitions including END1/END2 and watchdog.
REQ-027 start asserted outside IDLE SHALL be ignored; start held high through END1/END2 SHALL relaunch INIT1 one cycle after reaching IDLE.
REQ-028 Unused code 31 SHALL transition to IDLE next cycle.
REQ-029 Run latency: error detected at CHECK2 SHALL reach END2 in 7 cycles after start sampled.

Reset
REQ-030 reset=1 SHALL immediately set state=IDLE, timeout=0, loop counter=0, independent of clk.
REQ-031 Reset asserted mid-run SHALL abandon the run; no END state is entered on release.
REQ-032 First transition out of IDLE SHALL require start sampled on a clk edge after reset deasserts.

Configuration
REQ-033 Macro COV_FSM_WATCHDOG_EN SHALL enable a 16-bit LOOP1-entry counter, cleared on IDLE->INIT1.
REQ-034 With the macro: counter increments on each LOOP1 entry; when the entry making count equal WD_LIMIT occurs, next state SHALL be END2 instead of LOOP1 and timeout SHALL set, holding until next start or reset.
REQ-035 Without the macro: no counter is built, timeout SHALL be constant 0, loop is unbounded.

Verification
REQ-036 reset, start pulse, flag_s1=1 in INIT4 -> state 0,1,2,3,4,30,0.
REQ-037 Valid run, flags 0 in checks, flag_s1=1 in CHECK8 -> EXCHANGE1..3 (13,14,15) then 16,17,18.
REQ-038 In loop: flag_z1=0 at LOOP6 twice, then 1 at LOOP6 and 1 at LOOP11 -> two returns 23->18, then 23->24..28->29->0.
REQ-039 abort=1 during LOOP3 (20) -> state 0 next cycle; abort during END1 -> 0, no END2.
REQ-040 Watchdog build, WD_LIMIT=3, flag_z1 held 0 -> third LOOP1 entry replaced by END2 (30), timeout=1 until next start; non-watchdog build -> loop continues, timeout=0.
REQ-041 reset asserted between clk edges in LOOP9 -> state 0 asynchronously, timeout=0.
